// File: rtl/pattern_generator_if.sv
// Control/status bundle for the serial pattern generator.
// The generator uses the slave view; whoever starts runs uses master.
interface pattern_generator_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             a;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt,
        input  a, frame, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output a, frame, busy, done
    );
endinterface

// File: rtl/pattern_generator.sv
// Serial MSB-first pattern transmitter with repeat count and idle gaps.
// Define PATGEN_ABORT_EN to add an 'abort' input that cancels a busy run.
module pattern_generator #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input logic CLK,
    input logic reset_n,
`ifdef PATGEN_ABORT_EN
    input logic abort,
`endif
    pattern_generator_if.slave bus
);
    localparam int IW = $clog2(PAT_W);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [IW-1:0] MSB  = IW'(PAT_W - 1);
    localparam logic [GW-1:0] GTOP = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [CNT_W-1:0] rep_q, rep_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic [GW-1:0]    gap_q, gap_n;
    logic             a_q, a_n;
    logic             frame_q, frame_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            a_q     <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            rep_q   <= rep_n;
            idx_q   <= idx_n;
            gap_q   <= gap_n;
            a_q     <= a_n;
            frame_q <= frame_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Outputs are computed for the coming cycle and registered.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        rep_n   = rep_q;
        idx_n   = idx_q;
        gap_n   = gap_q;
        a_n     = 1'b0;
        frame_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pat_n = bus.pattern;
                    rep_n = bus.repeat_cnt;
                    idx_n = MSB;
                    if (bus.repeat_cnt != '0) begin
                        state_n = S_SHIFT;
                        a_n     = bus.pattern[MSB];
                        frame_n = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (idx_q != '0) begin
                    idx_n   = idx_q - 1'b1;
                    a_n     = pat_q[idx_q - 1'b1];
                    frame_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    // rep_q holds repetitions left including this one
                    rep_n = rep_q - 1'b1;
                    idx_n = MSB;
                    if (rep_q == CNT_W'(1)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else if (GAP == 0) begin
                        a_n     = pat_q[MSB];
                        frame_n = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_GAP;
                        gap_n   = GTOP;
                        busy_n  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                busy_n = 1'b1;
                if (gap_q == '0) begin
                    state_n = S_SHIFT;
                    a_n     = pat_q[MSB];
                    frame_n = 1'b1;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef PATGEN_ABORT_EN
        if (abort && busy_q) begin
            state_n = S_IDLE;
            a_n     = 1'b0;
            frame_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
`endif
    end

    assign bus.a     = a_q;
    assign bus.frame = frame_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: queue-based expected waveform plus
// hand-computed literal checks on bits, done timing and reset.
`timescale 1ns/1ps
module tb_pattern_generator;
    localparam int PW  = 4;
    localparam int CW  = 8;
    localparam int GP  = 2;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
`ifdef PATGEN_ABORT_EN
    logic abort = 1'b0;
`endif

    pattern_generator_if #(.PAT_W(PW), .CNT_W(CW)) g ();

    pattern_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(GP)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
`ifdef PATGEN_ABORT_EN
        .abort   (abort),
`endif
        .bus     (g.slave)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;

    // expected {a, frame, busy, done} per cycle
    logic [3:0] q[$];
    logic [3:0] exp_o = 4'b0000;

    task automatic build(input logic [PW-1:0] p, input int n);
        for (int r = 0; r < n; r++) begin
            for (int b = PW - 1; b >= 0; b--) q.push_back({p[b], 3'b110});
            if (r < n - 1)
                for (int k = 0; k < GP; k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
        q.push_back(4'b0000);
    endtask

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            exp_o = 4'b0000;
        end else begin
`ifdef PATGEN_ABORT_EN
            if (abort && exp_o[1]) begin
                q.delete();
                exp_o = 4'b0000;
            end else
`endif
            if (q.size() != 0) begin
                exp_o = q.pop_front();
            end else if (g.start) begin
                build(g.pattern, int'(g.repeat_cnt));
                exp_o = q.pop_front();
            end else begin
                exp_o = 4'b0000;
            end
        end
    end

    always @(negedge CLK) begin
        if (reset_n) begin
            compared++;
            if ({g.a, g.frame, g.busy, g.done} !== exp_o) begin
                mismatched++;
                $display("FAIL cycle_model t=%0t got afbd=%b want %b",
                         $time, {g.a, g.frame, g.busy, g.done}, exp_o);
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Starts a run and measures done index and first PW bits.
    task automatic run(input string nm, input logic [PW-1:0] p,
                       input logic [CW-1:0] n, input int want_done,
                       input logic [PW-1:0] want_bits, input bit glitch);
        int dc;
        logic [PW-1:0] bits;
        dc = -1;
        bits = '0;
        @(negedge CLK);
        g.start = 1'b1;
        g.pattern = p;
        g.repeat_cnt = n;
        @(negedge CLK);
        g.start = 1'b0;
        for (int c = 0; c < 3000 && dc < 0; c++) begin
            if (c < PW) bits[PW-1-c] = g.a;
            if (glitch && c == 2) begin
                g.start = 1'b1;
                g.pattern = '0;
                g.repeat_cnt = 8'd5;
            end
            if (glitch && c == 3) g.start = 1'b0;
            if (g.done) dc = c;
            else @(negedge CLK);
        end
        check({nm, "_done_idx"}, dc, want_done);
        if (n != 0) check({nm, "_bits"}, int'(bits), int'(want_bits));
    endtask

    initial begin
        g.start = 1'b0;
        g.pattern = '0;
        g.repeat_cnt = '0;
        #12;
        check("reset_outs", int'({g.a, g.frame, g.busy, g.done}), 0);
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        run("r1011_n1", 4'b1011, 8'd1, 4, 4'b1011, 1'b0);
        run("r1101_n3", 4'b1101, 8'd3, 16, 4'b1101, 1'b0);
        run("r_n0", 4'b1111, 8'd0, 0, 4'b0000, 1'b0);
        run("ignore", 4'b1011, 8'd1, 4, 4'b1011, 1'b1);
        run("r0110_n2", 4'b0110, 8'd2, 10, 4'b0110, 1'b0);
        run("r1010_max", 4'b1010, 8'd255, 1528, 4'b1010, 1'b0);

        // back-to-back with start held through done
        @(negedge CLK);
        g.start = 1'b1;
        g.pattern = 4'b1001;
        g.repeat_cnt = 8'd1;
        repeat (12) @(negedge CLK);
        g.start = 1'b0;
        repeat (8) @(negedge CLK);

        // async reset mid-run
        @(negedge CLK);
        g.start = 1'b1;
        g.pattern = 4'b1111;
        g.repeat_cnt = 8'd3;
        @(negedge CLK);
        g.start = 1'b0;
        repeat (2) @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", int'({g.a, g.frame, g.busy, g.done}), 0);
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("after_reset_idle", int'({g.a, g.frame, g.busy, g.done}), 0);

`ifdef PATGEN_ABORT_EN
        @(negedge CLK);
        g.start = 1'b1;
        g.pattern = 4'b1101;
        g.repeat_cnt = 8'd3;
        @(negedge CLK);
        g.start = 1'b0;
        repeat (5) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy", int'(g.busy), 0);
        check("abort_a", int'(g.a), 0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 15; c++) begin
                if (g.done) seen = 1;
                @(negedge CLK);
            end
            check("abort_no_done", seen, 0);
        end
`endif

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
